// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl : RV32 fetch-stage PC sequencer with deferred redirects     |
// | Revision   : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_ctrl #(
   parameter int                WIDTH       = 32,
   parameter logic [WIDTH-1:0]  RESET_PC    = '0,
   parameter int                BOOT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallF,
   input  logic             PCSrcE,
   input  logic [WIDTH-1:0] PCTargetE,
   input  logic             imem_ready,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] PCPlus4F,
   output logic             fetch_valid,
   output logic             FlushD,
   output logic             FlushE,
   output logic [15:0]      redirect_count
);

   localparam logic [1:0] c_ST_BOOT = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_WAIT = 2'd2;
   localparam int         c_BC_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   logic [1:0]        r_state, w_state_nxt;
   logic [WIDTH-1:0]  r_pc, w_pc_nxt;
   logic [c_BC_W-1:0] r_boot_cnt;
   logic              r_pend_valid, w_pend_valid_nxt;
   logic [WIDTH-1:0]  r_pend_target, w_pend_target_nxt;
   logic [15:0]       r_redirect_count;
   logic [WIDTH-1:0]  w_target;
   logic [WIDTH-1:0]  w_pc_plus4;
   logic              w_accept;
   logic              w_unused;

   // Redirect targets are always word aligned; the low bits are dropped.
   assign w_target   = {PCTargetE[WIDTH-1:2], 2'b00};
   assign w_unused   = ^PCTargetE[1:0];
   assign w_pc_plus4 = r_pc + WIDTH'(4);
   assign w_accept   = (r_state != c_ST_BOOT) && PCSrcE;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc             <= RESET_PC;
         r_boot_cnt       <= c_BC_W'(BOOT_CYCLES - 1);
         r_pend_valid     <= 1'b0;
         r_pend_target    <= '0;
         r_redirect_count <= '0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
         if (r_state == c_ST_BOOT && r_boot_cnt != '0) begin
            r_boot_cnt <= r_boot_cnt - c_BC_W'(1);
         end
         if (w_accept && r_redirect_count != 16'hFFFF) begin
            r_redirect_count <= r_redirect_count + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;
      case (r_state)
         c_ST_BOOT: begin
            if (r_boot_cnt == '0) begin
               w_state_nxt = c_ST_RUN;
            end
         end
         c_ST_RUN: begin
            if (!imem_ready) begin
               w_state_nxt = c_ST_WAIT;
               if (PCSrcE) begin
                  w_pend_valid_nxt  = 1'b1;
                  w_pend_target_nxt = w_target;
               end
            end else if (PCSrcE) begin
               w_pc_nxt = w_target;
            end else if (!StallF) begin
               w_pc_nxt = w_pc_plus4;
            end
         end
         c_ST_WAIT: begin
            if (!imem_ready) begin
               if (PCSrcE) begin
                  w_pend_valid_nxt  = 1'b1;
                  w_pend_target_nxt = w_target;
               end
            end else begin
               w_state_nxt      = c_ST_RUN;
               w_pend_valid_nxt = 1'b0;
               // A fresh redirect supersedes whatever was deferred.
               if (PCSrcE) begin
                  w_pc_nxt = w_target;
               end else if (r_pend_valid) begin
                  w_pc_nxt = r_pend_target;
               end else if (!StallF) begin
                  w_pc_nxt = w_pc_plus4;
               end
            end
         end
         default: begin
            w_state_nxt = c_ST_BOOT;
         end
      endcase
   end

   always_comb begin
      FlushD      = w_accept;
      FlushE      = w_accept;
      fetch_valid = (r_state != c_ST_BOOT) && imem_ready && !StallF
                    && !PCSrcE && !r_pend_valid;
   end

   assign PCF            = r_pc;
   assign PCPlus4F       = w_pc_plus4;
   assign redirect_count = r_redirect_count;

endmodule
`default_nettype wire
